frame_sequencer: RTL and testbench

Top-level scheduler for the falling-object game. It drives the 16x32 VGA adapter write port by scanning the 512-bit display vector, one pixel per clock. It paces the game by issuing a one-cycle shift_en (scroll down one row) every FRAMES_PER_STEP frame ticks and a spawn_en (load new 16x16 shape into the top buffer) every STEPS_PER_SPAWN steps. It replaces the ad-hoc frame/delay/x/y counters in the top level.

---
 rtl/frame_seq_pkg.sv | 22 ++
 rtl/frame_sequencer_tick_divider.sv | 29 ++
 rtl/frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared types and geometry for the frame sequencer: FSM states and the
// 16x32 playfield dimensions used by the VGA scan.
package frame_seq_pkg;

  localparam int unsigned NUM_COLS   = 16;
  localparam int unsigned NUM_ROWS   = 32;
  localparam int unsigned NUM_PIXELS = NUM_COLS * NUM_ROWS;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    WAIT,
    STEP,
    SPAWN
  } state_t;

  // Display bit index 32*x+y; with power-of-two rows this is a plain concat.
  function automatic logic [8:0] pixel_index(input logic [3:0] px, input logic [4:0] py);
    return {px, py};
  endfunction

endpackage

// File: rtl/frame_sequencer_tick_divider.sv
// Frame tick divider: counts down while enabled, pulses tick on the
// terminal count and reloads.
module tick_divider #(
  parameter int unsigned TICK_CYCLES = 833334
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= CW'(TICK_CYCLES - 1);
    end else if (enable) begin
      if (count == '0) count <= CW'(TICK_CYCLES - 1);
      else             count <= count - 1'b1;
    end
  end

  always_comb begin
    tick = enable && (count == '0);
  end

endmodule

// File: rtl/frame_sequencer.sv
// Game scheduler: scans a snapshot of the 512-bit playfield into the VGA
// write port and paces row shifts and shape spawns from frame ticks.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned TICK_CYCLES     = 833334,
  parameter int unsigned FRAMES_PER_STEP = 16,
  parameter int unsigned STEPS_PER_SPAWN = 16,
  parameter logic [2:0]  FG_COLOUR       = 3'b111,
  parameter logic [2:0]  BG_COLOUR       = 3'b000
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  run,
  input  logic [NUM_PIXELS-1:0] display,
  output logic [3:0]            x,
  output logic [4:0]            y,
  output logic [2:0]            colour,
  output logic                  plot,
  output logic                  shift_en,
  output logic                  spawn_en,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int unsigned PW = $clog2(NUM_PIXELS);
  localparam int unsigned YW = $clog2(NUM_ROWS);

  state_t                state, state_nxt;
  logic [PW-1:0]         p;
  logic [NUM_PIXELS-1:0] snap;
  logic [7:0]            frame_cnt;
  logic [7:0]            step_cnt;
  logic                  tick;
  logic                  tick_pending;
  logic                  settle;
  logic                  flush;
  logic                  consume;
  logic                  load_snap;
  logic                  start_settle;

  tick_divider #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_div (
    .clock (clock),
    .resetn(resetn),
    .enable(run),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    consume      = 1'b0;
    load_snap    = 1'b0;
    start_settle = 1'b0;
    shift_en     = 1'b0;
    spawn_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) begin
          state_nxt = DRAW;
          load_snap = 1'b1;
        end
      end
      DRAW: begin
        if (flush) state_nxt = run ? WAIT : IDLE;
      end
      WAIT: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (tick_pending) begin
          consume = 1'b1;
          if (frame_cnt == 8'(FRAMES_PER_STEP - 1)) begin
            state_nxt = STEP;
          end else begin
            state_nxt = DRAW;
            load_snap = 1'b1;
          end
        end
      end
      STEP: begin
        shift_en = 1'b1;
        if (step_cnt == 8'(STEPS_PER_SPAWN - 1)) begin
          state_nxt = SPAWN;
        end else begin
          state_nxt    = DRAW;
          start_settle = 1'b1;
        end
      end
      SPAWN: begin
        spawn_en     = 1'b1;
        state_nxt    = DRAW;
        start_settle = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // DRAW carries two sub-phases: settle (one dead cycle so game_state's
  // registered update lands before the snapshot) and flush (frame_done).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p            <= '0;
      snap         <= '0;
      frame_cnt    <= '0;
      step_cnt     <= '0;
      tick_pending <= 1'b0;
      overrun      <= 1'b0;
      settle       <= 1'b0;
      flush        <= 1'b0;
      x            <= '0;
      y            <= '0;
      colour       <= BG_COLOUR;
      plot         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      plot       <= 1'b0;
      frame_done <= 1'b0;

      if (tick && tick_pending) overrun <= 1'b1;
      if (tick)         tick_pending <= 1'b1;
      else if (consume) tick_pending <= 1'b0;

      if (load_snap) begin
        snap <= display;
        p    <= '0;
      end
      if (start_settle) settle <= 1'b1;

      if (consume) begin
        if (frame_cnt == 8'(FRAMES_PER_STEP - 1)) frame_cnt <= '0;
        else                                      frame_cnt <= frame_cnt + 1'b1;
      end

      if (state == STEP) begin
        if (step_cnt == 8'(STEPS_PER_SPAWN - 1)) step_cnt <= '0;
        else                                     step_cnt <= step_cnt + 1'b1;
      end

      if (state == DRAW) begin
        if (settle) begin
          settle <= 1'b0;
          snap   <= display;
          p      <= '0;
        end else if (flush) begin
          flush      <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          x      <= p[PW-1:YW];
          y      <= p[YW-1:0];
          colour <= snap[pixel_index(p[PW-1:YW], p[YW-1:0])] ? FG_COLOUR : BG_COLOUR;
          plot   <= 1'b1;
          p      <= p + 1'b1;
          if (p == PW'(NUM_PIXELS - 1)) flush <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: expected pixels are queued per frame
// and checked by a monitor as the DUT plots them.
module tb_frame_sequencer;
  import frame_seq_pkg::*;

  logic         clock = 1'b0;
  logic         resetn, run, resetn_ov, run_ov;
  logic [511:0] display, display_ov;
  logic [3:0]   x, x_ov;
  logic [4:0]   y, y_ov;
  logic [2:0]   colour, colour_ov;
  logic         plot, shift_en, spawn_en, frame_done, overrun;
  logic         plot_ov, shift_en_ov, spawn_en_ov, frame_done_ov, overrun_ov;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  frame_sequencer #(
    .TICK_CYCLES(600), .FRAMES_PER_STEP(2), .STEPS_PER_SPAWN(3)
  ) dut (
    .clock(clock), .resetn(resetn), .run(run), .display(display),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .shift_en(shift_en), .spawn_en(spawn_en),
    .frame_done(frame_done), .overrun(overrun)
  );

  // Tick period shorter than a frame so ticks pile up behind the scan.
  frame_sequencer #(
    .TICK_CYCLES(300), .FRAMES_PER_STEP(1), .STEPS_PER_SPAWN(1)
  ) dut_ov (
    .clock(clock), .resetn(resetn_ov), .run(run_ov), .display(display_ov),
    .x(x_ov), .y(y_ov), .colour(colour_ov), .plot(plot_ov),
    .shift_en(shift_en_ov), .spawn_en(spawn_en_ov),
    .frame_done(frame_done_ov), .overrun(overrun_ov)
  );

  typedef struct packed {
    logic [3:0] px;
    logic [4:0] py;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [511:0] d);
    pix_t e;
    for (int i = 0; i < 512; i++) begin
      e.px = 4'(i / 32);
      e.py = 5'(i % 32);
      e.c  = d[32 * (i / 32) + (i % 32)] ? 3'b111 : 3'b000;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_frame_done(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (frame_done) break;
    end
    check(tag, 32'(frame_done), 1);
  endtask

  task automatic wait_pixel(input string tag, input logic [3:0] px, input logic [4:0] py,
                            input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (plot && x == px && y == py) break;
    end
    check(tag, {plot, x, y}, {1'b1, px, py});
  endtask

  // Reference model of the main tick divider: counts cycles with run high.
  int run_cycles = 0;
  always @(posedge clock) begin
    if (!resetn)  run_cycles = 0;
    else if (run) run_cycles++;
  end

  // Pixel/pulse monitor.
  int         run_len = 0;
  int         shift_cnt = 0, spawn_cnt = 0, fd_cnt = 0;
  logic       prev_plot = 1'b0, prev_shift = 1'b0;
  logic [3:0] last_x = '0;
  logic [4:0] last_y = '0;
  pix_t       e_mon;

  always @(negedge clock) begin
    if (!resetn) begin
      run_len    = 0;
      prev_plot  = 1'b0;
      prev_shift = 1'b0;
    end else begin
      if (plot) begin
        if (exp_q.size() == 0) begin
          check("unexpected_plot", 32'(plot), 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("pixel", {x, y, colour}, e_mon);
        end
        run_len++;
        last_x = x;
        last_y = y;
      end else if (prev_plot) begin
        check("plot_run_len", run_len, 512);
        run_len = 0;
      end
      if (frame_done) begin
        fd_cnt++;
        check("frame_done_after_last", {prev_plot, last_x, last_y}, {1'b1, 4'd15, 5'd31});
      end
      if (spawn_en) begin
        spawn_cnt++;
        check("spawn_after_shift", {prev_shift, shift_en}, 2'b10);
      end
      if (shift_en) shift_cnt++;
      prev_plot  = plot;
      prev_shift = shift_en;
    end
  end

  logic [511:0] disp, disp_new;

  initial begin
    resetn     = 1'b0;
    resetn_ov  = 1'b0;
    run        = 1'b0;
    run_ov     = 1'b0;
    display    = '0;
    display_ov = '0;
    #1;
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_colour", 32'(colour), 0);
    check("rst_plot", 32'(plot), 0);
    check("rst_shift", 32'(shift_en), 0);
    check("rst_spawn", 32'(spawn_en), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    repeat (3) @(negedge clock);
    resetn    = 1'b1;
    resetn_ov = 1'b1;

    // Scan order and colour: only pixel (3,5) lit.
    disp      = '0;
    disp[101] = 1'b1;
    display   = disp;
    push_frame(disp);
    @(negedge clock);
    run = 1'b1;
    wait_frame_done("scan_frame_done", 1200);
    #1;
    check("scan_queue_drained", 32'(exp_q.size()), 0);
    check("scan_frame_done_count", 32'(fd_cnt), 1);

    // Pacing over six ticks: shift on even ticks, spawn after the third shift.
    for (int t = 1; t <= 6; t++) begin
      push_frame(disp);
      wait_frame_done("pace_frame_done", 1500);
      #1;
      check("pace_shift_count", 32'(shift_cnt), 32'(t / 2));
      check("pace_spawn_count", 32'(spawn_cnt), (t == 6) ? 1 : 0);
    end

    // Tear-free: toggle pixel (0,0) mid-frame.
    push_frame(disp);
    wait_pixel("tear_mid", 4'd6, 5'd8, 1500);
    disp_new    = disp;
    disp_new[0] = 1'b1;
    display     = disp_new;
    wait_frame_done("tear_old_frame_done", 600);
    push_frame(disp_new);
    wait_frame_done("tear_new_frame_done", 1500);

    // Stop mid-frame: frame completes, then IDLE with the divider frozen.
    push_frame(disp_new);
    wait_pixel("stop_mid", 4'd3, 5'd4, 1500);
    run = 1'b0;
    wait_frame_done("stop_frame_done", 600);
    check("stop_state_idle", 32'(dut.state), 32'(IDLE));
    repeat (50) @(negedge clock);
    check("stop_tick_hold", 32'(dut.u_div.count), 32'(599 - (run_cycles % 600)));
    #1;
    check("stop_queue_drained", 32'(exp_q.size()), 0);

    // Restart from IDLE, then drop run while in WAIT.
    push_frame(disp_new);
    run = 1'b1;
    wait_frame_done("restart_frame_done", 1200);
    check("restart_in_wait", 32'(dut.state), 32'(WAIT));
    run = 1'b0;
    @(negedge clock);
    check("wait_to_idle", 32'(dut.state), 32'(IDLE));

    // Async reset mid-frame.
    push_frame(disp_new);
    run = 1'b1;
    wait_pixel("rst_mid", 4'd9, 5'd12, 1500);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_plot", 32'(plot), 0);
    check("arst_x", 32'(x), 0);
    check("arst_y", 32'(y), 0);
    check("arst_colour", 32'(colour), 0);
    check("arst_pulses", {shift_en, spawn_en, frame_done}, 0);
    check("arst_overrun", 32'(overrun), 0);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    push_frame(disp_new);
    wait_frame_done("post_reset_frame_done", 1200);
    run = 1'b0;
    @(negedge clock);
    #1;
    check("post_reset_queue_drained", 32'(exp_q.size()), 0);

    // Overrun: sticky until reset.
    run_ov = 1'b1;
    repeat (450) @(negedge clock);
    check("ov_early_clear", 32'(overrun_ov), 0);
    repeat (750) @(negedge clock);
    check("ov_set", 32'(overrun_ov), 1);
    repeat (1000) @(negedge clock);
    check("ov_sticky", 32'(overrun_ov), 1);
    #2;
    resetn_ov = 1'b0;
    #1;
    check("ov_reset_clear", 32'(overrun_ov), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
